// File: rtl/fetch_queue_pkg.sv
// Fetch queue shared types and constants.
// Entry layout, widths, nop encoding and reset PC.
package fetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: circular buffer of entries,
// head/tail pointers, occupancy and synchronous flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fq_entry_t        wdata,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             full
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign do_pop  = pop & valid & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Storage is never cleared; an empty count masks stale data.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[tail_ptr] <= wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: PCF register feeding a
// small queue in front of decode, with redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 10,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Redirect,
  input  logic [31:0]       RedirectPC,
  input  logic              PauseD,
  output logic [ADDR_W-1:0] ImAddr,
  input  logic [31:0]       ImInstr,
  output logic [31:0]       IRD,
  output logic [31:0]       PC4D,
  output logic              ValidD,
  output logic [CNT_W-1:0]  Count
);

  logic [XLEN-1:0] pcf;
  logic            push;
  logic            pop;
  logic            full;
  fq_entry_t       wr_entry;
  fq_entry_t       head;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^RedirectPC[1:0];

  assign ImAddr = pcf[ADDR_W+1:2];

  assign pop  = ValidD & ~PauseD & ~Redirect;
  assign push = ~Redirect & (~full | pop);

  assign wr_entry.instr = ImInstr;
  assign wr_entry.pc4   = pc_plus4(pcf);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pcf <= RESET_PC;
    end else if (Redirect) begin
      pcf <= {RedirectPC[31:2], 2'b00};
    end else if (push) begin
      pcf <= pc_plus4(pcf);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .flush  (Redirect),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_entry),
    .head   (head),
    .count  (Count),
    .valid  (ValidD),
    .full   (full)
  );

  // Decode side sees only registered state, zeroed when empty.
  assign IRD  = ValidD ? head.instr : NOP_INSTR;
  assign PC4D = ValidD ? head.pc4 : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed
// stall/redirect/reset sequences against a word-index memory.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Redirect;
  logic [31:0]       RedirectPC;
  logic              PauseD;
  logic [ADDR_W-1:0] ImAddr;
  logic [31:0]       ImInstr;
  logic [31:0]       IRD;
  logic [31:0]       PC4D;
  logic              ValidD;
  logic [CNT_W-1:0]  Count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  assign ImInstr = 32'hC0DE_0000 | {22'h0, ImAddr};

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_3000)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .PauseD    (PauseD),
    .ImAddr    (ImAddr),
    .ImInstr   (ImInstr),
    .IRD       (IRD),
    .PC4D      (PC4D),
    .ValidD    (ValidD),
    .Count     (Count)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return 32'hC0DE_0000 | {22'h0, pc[11:2]};
  endfunction

  task automatic expect_from(input logic [31:0] pc);
    exp_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.instr = instr_at(pc);
      e.pc4   = pc + 32'd4;
      sb.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Monitor: every consumed head must match the next expected fetch.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (Reset_n === 1'b1) begin
      if (ValidD && !PauseD && !Redirect) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got IRD %h expected no pop", IRD);
        end else begin
          e = sb.pop_front();
          check("ird", IRD, e.instr);
          check("pc4d", PC4D, e.pc4);
        end
      end else if (!ValidD) begin
        check("ird_empty", IRD, 32'h0);
        check("pc4d_empty", PC4D, 32'h0);
      end
    end
  end

  initial begin
    Reset_n    = 1'b0;
    Redirect   = 1'b0;
    PauseD     = 1'b0;
    RedirectPC = 32'h0;
    tick(2);
    check("rst_valid", {31'h0, ValidD}, 32'h0);
    check("rst_ird", IRD, 32'h0);
    check("rst_pc4d", PC4D, 32'h0);
    check("rst_count", {29'h0, Count}, 32'h0);
    check("rst_imaddr", {22'h0, ImAddr}, 32'h0);

    // Straight-line flow from reset
    expect_from(32'h3000);
    Reset_n = 1'b1;
    check("rel_valid", {31'h0, ValidD}, 32'h0);
    tick(1);
    check("first_valid", {31'h0, ValidD}, 32'h1);
    check("flow_count", {29'h0, Count}, 32'h1);
    tick(8);
    check("flow_count2", {29'h0, Count}, 32'h1);

    // Stall from reset until the queue saturates
    PauseD  = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, ValidD}, 32'h0);
    check("async_rst_count", {29'h0, Count}, 32'h0);
    expect_from(32'h3000);
    tick(1);
    Reset_n = 1'b1;
    tick(4);
    check("sat_count", {29'h0, Count}, 32'h4);
    check("sat_imaddr", {22'h0, ImAddr}, 32'h4);
    tick(6);
    check("hold_count", {29'h0, Count}, 32'h4);
    check("hold_imaddr", {22'h0, ImAddr}, 32'h4);
    check("hold_ird", IRD, instr_at(32'h3000));
    check("hold_pc4d", PC4D, 32'h3004);
    PauseD = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("full_count", {29'h0, Count}, 32'h4);
      check("full_valid", {31'h0, ValidD}, 32'h1);
    end

    // Redirect with three entries queued
    PauseD  = 1'b1;
    Reset_n = 1'b0;
    sb.delete();
    tick(1);
    Reset_n = 1'b1;
    tick(3);
    check("pre_redir_count", {29'h0, Count}, 32'h3);
    PauseD     = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_3101;
    expect_from(32'h3100);
    tick(1);
    Redirect = 1'b0;
    check("redir_count", {29'h0, Count}, 32'h0);
    check("redir_valid", {31'h0, ValidD}, 32'h0);
    check("redir_ird", IRD, 32'h0);
    check("redir_imaddr", {22'h0, ImAddr}, 32'h40);
    tick(1);
    check("redir_next_valid", {31'h0, ValidD}, 32'h1);
    tick(4);

    // Redirect and stall together on a full queue
    PauseD = 1'b1;
    tick(4);
    check("full_pre_flush", {29'h0, Count}, 32'h4);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_3200;
    expect_from(32'h3200);
    tick(1);
    Redirect = 1'b0;
    check("flush_count", {29'h0, Count}, 32'h0);
    check("flush_valid", {31'h0, ValidD}, 32'h0);
    tick(1);
    check("flush_refill", {29'h0, Count}, 32'h1);
    check("flush_ird", IRD, instr_at(32'h3200));
    check("flush_pc4d", PC4D, 32'h3204);
    PauseD = 1'b0;
    tick(5);

    // PC wrap across 2^32
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    expect_from(32'hFFFF_FFFC);
    tick(1);
    Redirect = 1'b0;
    tick(4);

    // Asynchronous reset mid-cycle
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_ird", IRD, 32'h0);
    check("mid_rst_pc4d", PC4D, 32'h0);
    check("mid_rst_valid", {31'h0, ValidD}, 32'h0);
    check("mid_rst_count", {29'h0, Count}, 32'h0);
    check("mid_rst_imaddr", {22'h0, ImAddr}, 32'h0);
    expect_from(32'h3000);
    #3;
    Reset_n = 1'b1;
    tick(1);
    check("post_mid_valid", {31'h0, ValidD}, 32'h1);
    check("post_mid_ird", IRD, instr_at(32'h3000));
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 10, instruction-memory word-index width.
REQ-003 Parameter RESET_PC, default 32'h0000_3000, first fetch address.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Redirect  input  1  taken branch/jump/jr resolved in D; flush queue and restart fetch.
REQ-007 RedirectPC  input  32  target address for Redirect.
REQ-008 PauseD  input  1  decode stalled; head entry is not consumed.
REQ-009 ImAddr  output  ADDR_W  combinational word index PCF[ADDR_W+1:2] to instruction memory.
REQ-010 ImInstr  input  32  combinational instruction read at ImAddr, same cycle.
REQ-011 IRD  output  32  head-entry instruction to decode; 32'h0 (nop) when empty.
REQ-012 PC4D  output  32  head-entry fetch PC + 4; 32'h0 when empty.
REQ-013 ValidD  output  1  head entry valid (queue not empty).
REQ-014 Count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-015 Internal PCF register holds the next fetch address; ImAddr is derived only from PCF.
REQ-016 pop = ValidD & ~PauseD & ~Redirect.
REQ-017 push = ~Redirect & (Count < DEPTH | pop); push writes {ImInstr, PCF+4} at tail and sets PCF <= PCF+4.
REQ-018 Full queue with simultaneous pop: push is performed; Count stays DEPTH.
REQ-019 Empty queue: pop is impossible; push makes the entry visible on IRD/PC4D after that edge (one-cycle fetch-to-decode latency, identical to a plain pipeline register).
REQ-020 Redirect has priority over push and pop: at the edge, all entries are discarded (Count <= 0, pointers equalised), PCF <= {RedirectPC[31:2], 2'b00}, nothing pushed.
REQ-021 Cycle after Redirect: queue empty, ValidD=0, IRD=0; fetch from RedirectPC proceeds.
REQ-022 Redirect while PauseD=1: flush still occurs; stalled head is discarded.
REQ-023 Head/tail pointers wrap modulo DEPTH; Count updates +1 (push only), -1 (pop only), unchanged (both or neither).
REQ-024 PCF+4 wraps modulo 2^32; no overflow flag.
REQ-025 IRD/PC4D/ValidD are driven from registered state only, never combinationally from ImInstr or Redirect.
REQ-026 Queue entries store 64 bits: instruction and PC+4.

Reset
REQ-027 Reset_n low asynchronously forces PCF=RESET_PC, pointers=0, Count=0, ValidD=0, IRD=0, PC4D=0.
REQ-028 Entry storage is not cleared; emptiness masks it.
REQ-029 Reset asserted mid-operation discards in-flight entries; first push occurs on the first rising edge after Reset_n deasserts.

Structure
REQ-030 Shared package holds NOP_INSTR (32'h0), default RESET_PC, and instruction/PC widths.
REQ-031 One sub-module fetch_fifo (parametrised storage, pointers, Count, flush input); fetch_queue owns PCF and push/pop/redirect logic.

Verification
REQ-032 Reset release, PauseD=0, memory word k = k: IRD sequence 0 (empty), then instr@0x3000, @0x3004, ... one per cycle; PC4D = 0x3004, 0x3008, ...
REQ-033 PauseD=1 for 10 cycles from reset: Count saturates at DEPTH (4) after 4 edges, PCF stops at 0x3010, IRD holds instr@0x3000; release PauseD -> consecutive instructions with no gaps.
REQ-034 Full queue, PauseD=0: push and pop each cycle, Count stays 4, pointers wrap past index 3 without loss or duplication.
REQ-035 Redirect=1, RedirectPC=0x3101 with Count=3: next cycle Count=0, ValidD=0, IRD=0; following cycle IRD=instr@0x3100, PC4D=0x3104.
REQ-036 Redirect and PauseD asserted together with full queue: flush wins, no push; Reset_n pulsed low mid-run: outputs zero immediately without a clock edge, PCF=0x3000.
